// File: rtl/axi_apb_pkg.sv
// rtl/axi_apb_pkg.sv - shared types and constants for the AXI-to-APB read/write arbiter
//
// Purpose : arbiter state encoding, default widths, slave-select field
//           constants and the one-hot select helper.
// Ports   : none (package).
package axi_apb_pkg;

  localparam int DEF_ADDR_WIDTH   = 32;
  localparam int DEF_LEN_WIDTH    = 8;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_SEL_LSB      = 4;

  // Two address bits pick one of four APB slaves.
  localparam int SEL_FIELD_WIDTH  = 2;
  localparam int SEL_COUNT        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  function automatic logic [SEL_COUNT-1:0] sel_onehot(input logic [SEL_FIELD_WIDTH-1:0] i_field);
    return SEL_COUNT'(1) << i_field;
  endfunction

endpackage

// File: rtl/apb_slave_decoder.sv
// rtl/apb_slave_decoder.sv - address to one-hot PSEL1..PSEL4 decode
//
// Purpose : decode the 2-bit slave-select field of an address into a
//           one-hot select vector.
// Ports   : i_addr - full address
//           o_sel  - one-hot select, bit 0 = PSEL1
module apb_slave_decoder
  import axi_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SEL_LSB    = DEF_SEL_LSB
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [SEL_COUNT-1:0]  o_sel
);

  // Only the select field matters; the rest of the address is folded
  // into a deliberately unused net.
  logic w_unused_addr;
  assign w_unused_addr = ^i_addr;

  assign o_sel = sel_onehot(i_addr[SEL_LSB+SEL_FIELD_WIDTH-1:SEL_LSB]);

endmodule

// File: rtl/axi_apb_rw_arbiter.sv
// rtl/axi_apb_rw_arbiter.sv - read/write burst arbiter driving a shared APB master
//
// Purpose : grants the APB master to a pending write or read burst, sequences
//           the per-beat apb_start pulses, and limits write starvation of reads.
// Ports   : ACLK, ARESET           - clock, sync active-high reset
//           wr_req/addr/len        - pending write burst
//           rd_req/addr/len        - pending read burst
//           apb_beat_done          - one APB transfer completed
//           wr_grant, rd_grant     - current burst owner
//           apb_start, apb_write   - start pulse and direction of next transfer
//           beat_cnt, burst_done   - beats completed, end-of-burst pulse
//           slv_sel                - one-hot PSEL decode while granted
//           busy                   - arbiter not in IDLE
module axi_apb_rw_arbiter
  import axi_apb_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH    = DEF_LEN_WIDTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int SEL_LSB      = DEF_SEL_LSB
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [LEN_WIDTH-1:0]  wr_len,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [LEN_WIDTH-1:0]  rd_len,
  input  logic                  apb_beat_done,
  output logic                  wr_grant,
  output logic                  rd_grant,
  output logic                  apb_start,
  output logic                  apb_write,
  output logic [LEN_WIDTH-1:0]  beat_cnt,
  output logic                  burst_done,
  output logic [SEL_COUNT-1:0]  slv_sel,
  output logic                  busy
);

  localparam int                  STREAK_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  arb_state_t            r_state;
  logic                  r_wr_grant;
  logic                  r_rd_grant;
  logic                  r_apb_start;
  logic                  r_burst_done;
  logic                  r_busy;
  logic [LEN_WIDTH-1:0]  r_beat_cnt;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [STREAK_W-1:0]   r_wr_streak;

  logic                  w_pick_wr;
  logic                  w_last_beat;
  logic [SEL_COUNT-1:0]  w_dec_sel;

  // Writes win by default. A read pre-empts only once the write streak has
  // hit its limit, and never when it targets the address being written, so
  // a read can never overtake the write it depends on.
  assign w_pick_wr   = wr_req && (!rd_req || (wr_addr == rd_addr) || (r_wr_streak != STREAK_MAX));
  assign w_last_beat = (r_beat_cnt == r_len);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state      <= IDLE;
      r_wr_grant   <= 1'b0;
      r_rd_grant   <= 1'b0;
      r_apb_start  <= 1'b0;
      r_burst_done <= 1'b0;
      r_busy       <= 1'b0;
      r_beat_cnt   <= '0;
      r_len        <= '0;
      r_addr       <= '0;
      r_wr_streak  <= '0;
    end else begin
      r_apb_start  <= 1'b0;
      r_burst_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (wr_req || rd_req) begin
            r_busy      <= 1'b1;
            r_beat_cnt  <= '0;
            r_apb_start <= 1'b1;
            if (w_pick_wr) begin
              r_state    <= WR;
              r_wr_grant <= 1'b1;
              r_addr     <= wr_addr;
              r_len      <= wr_len;
              if (r_wr_streak != STREAK_MAX) begin
                r_wr_streak <= r_wr_streak + STREAK_W'(1);
              end
            end else begin
              r_state     <= RD;
              r_rd_grant  <= 1'b1;
              r_addr      <= rd_addr;
              r_len       <= rd_len;
              r_wr_streak <= '0;
            end
          end
        end
        WR, RD: begin
          if (apb_beat_done) begin
            // Wraps to 0 only after the final beat of a maximum-length burst.
            r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
            if (w_last_beat) begin
              r_state      <= DONE;
              r_wr_grant   <= 1'b0;
              r_rd_grant   <= 1'b0;
              r_burst_done <= 1'b1;
            end else begin
              r_apb_start <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  apb_slave_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SEL_LSB    (SEL_LSB)
  ) u_slave_decoder (
    .i_addr (r_addr),
    .o_sel  (w_dec_sel)
  );

  assign wr_grant   = r_wr_grant;
  assign rd_grant   = r_rd_grant;
  assign apb_start  = r_apb_start;
  assign apb_write  = r_wr_grant;
  assign beat_cnt   = r_beat_cnt;
  assign burst_done = r_burst_done;
  assign busy       = r_busy;
  assign slv_sel    = (r_wr_grant || r_rd_grant) ? w_dec_sel : '0;

endmodule

// File: tb/tb_axi_apb_rw_arbiter.sv
// tb/tb_axi_apb_rw_arbiter.sv - directed self-checking bench for axi_apb_rw_arbiter
module tb_axi_apb_rw_arbiter;

  localparam int AW = 32;
  localparam int LW = 8;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [LW-1:0] wr_len;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [LW-1:0] rd_len;
  logic          apb_beat_done;
  logic          wr_grant;
  logic          rd_grant;
  logic          apb_start;
  logic          apb_write;
  logic [LW-1:0] beat_cnt;
  logic          burst_done;
  logic [3:0]    slv_sel;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  always #5 ACLK = ~ACLK;

  axi_apb_rw_arbiter #(
    .ADDR_WIDTH   (AW),
    .LEN_WIDTH    (LW),
    .STARVE_LIMIT (4),
    .SEL_LSB      (4)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_len        (wr_len),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_len        (rd_len),
    .apb_beat_done (apb_beat_done),
    .wr_grant      (wr_grant),
    .rd_grant      (rd_grant),
    .apb_start     (apb_start),
    .apb_write     (apb_write),
    .beat_cnt      (beat_cnt),
    .burst_done    (burst_done),
    .slv_sel       (slv_sel),
    .busy          (busy)
  );

  // Observed vector: {wr_grant, rd_grant, apb_start, apb_write, busy, burst_done, slv_sel, beat_cnt}
  function automatic logic [17:0] obs();
    return {wr_grant, rd_grant, apb_start, apb_write, busy, burst_done, slv_sel, beat_cnt};
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic apply_reset();
    wr_req = 1'b0; rd_req = 1'b0; apb_beat_done = 1'b0;
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
  endtask

  // Caller leaves the DUT in IDLE with its request(s) applied.
  task automatic run_burst(input bit is_wr, input int len, input logic [3:0] exp_sel,
                           input bit drop, input string name);
    logic [17:0] exp;
    logic [7:0]  cnt;
    tick();
    if (drop) begin
      if (is_wr) wr_req = 1'b0;
      else       rd_req = 1'b0;
    end
    for (int i = 0; i <= len; i++) begin
      cnt = 8'(i);
      exp = {is_wr, ~is_wr, 1'b1, is_wr, 1'b1, 1'b0, exp_sel, cnt};
      checks++;
      if (obs() !== exp) begin
        failures++;
        $display("FAIL %s beat %0d: got %b expected %b", name, i, obs(), exp);
      end
      apb_beat_done = 1'b1;
      tick();
      apb_beat_done = 1'b0;
    end
    cnt = 8'(len + 1);
    exp = {6'b000011, 4'b0000, cnt};
    checks++;
    if (obs() !== exp) begin
      failures++;
      $display("FAIL %s done: got %b expected %b", name, obs(), exp);
    end
    tick();
    exp = {6'b000000, 4'b0000, cnt};
    checks++;
    if (obs() !== exp) begin
      failures++;
      $display("FAIL %s idle: got %b expected %b", name, obs(), exp);
    end
  endtask

  task automatic test_reset();
    wr_addr = 32'd9; wr_len = 8'd0; rd_addr = 32'd0; rd_len = 8'd0;
    wr_req = 1'b1; rd_req = 1'b0; apb_beat_done = 1'b0;
    ARESET = 1'b1;
    tick();
    tick();
    checks++;
    if (obs() !== 18'd0) begin
      failures++;
      $display("FAIL reset_state: got %b expected %b", obs(), 18'd0);
    end
    wr_req = 1'b0;
    ARESET = 1'b0;
    tick();
    checks++;
    if (obs() !== 18'd0) begin
      failures++;
      $display("FAIL reset_idle: got %b expected %b", obs(), 18'd0);
    end
  endtask

  task automatic test_idle_beat_ignored();
    apply_reset();
    apb_beat_done = 1'b1;
    tick();
    tick();
    apb_beat_done = 1'b0;
    checks++;
    if (obs() !== 18'd0) begin
      failures++;
      $display("FAIL idle_beat_ignored: got %b expected %b", obs(), 18'd0);
    end
  endtask

  task automatic test_single_write();
    apply_reset();
    wr_addr = 32'd9; wr_len = 8'd0; wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    checks++;
    if (obs() !== {6'b101110, 4'b0001, 8'd0}) begin
      failures++;
      $display("FAIL single_wr_grant: got %b expected %b", obs(), {6'b101110, 4'b0001, 8'd0});
    end
    tick();
    checks++;
    if (obs() !== {6'b100110, 4'b0001, 8'd0}) begin
      failures++;
      $display("FAIL single_wr_wait: got %b expected %b", obs(), {6'b100110, 4'b0001, 8'd0});
    end
    apb_beat_done = 1'b1;
    tick();
    apb_beat_done = 1'b0;
    checks++;
    if (obs() !== {6'b000011, 4'b0000, 8'd1}) begin
      failures++;
      $display("FAIL single_wr_done: got %b expected %b", obs(), {6'b000011, 4'b0000, 8'd1});
    end
    tick();
    checks++;
    if (obs() !== {6'b000000, 4'b0000, 8'd1}) begin
      failures++;
      $display("FAIL single_wr_idle: got %b expected %b", obs(), {6'b000000, 4'b0000, 8'd1});
    end
  endtask

  task automatic test_read_burst();
    apply_reset();
    rd_addr = 32'd58; rd_len = 8'd7; rd_req = 1'b1;
    run_burst(1'b0, 7, 4'b1000, 1'b1, "rd_burst");
  endtask

  task automatic test_simultaneous();
    apply_reset();
    wr_addr = 32'd9;  wr_len = 8'd1; wr_req = 1'b1;
    rd_addr = 32'd38; rd_len = 8'd2; rd_req = 1'b1;
    run_burst(1'b1, 1, 4'b0001, 1'b1, "sim_wr");
    run_burst(1'b0, 2, 4'b0100, 1'b1, "sim_rd");
  endtask

  task automatic test_starvation();
    apply_reset();
    wr_addr = 32'd9;  wr_len = 8'd0; wr_req = 1'b1;
    rd_addr = 32'd47; rd_len = 8'd0; rd_req = 1'b1;
    for (int k = 0; k < 4; k++) run_burst(1'b1, 0, 4'b0001, 1'b0, "starve_wr");
    run_burst(1'b0, 0, 4'b0100, 1'b1, "starve_rd");
    wr_req = 1'b0;
  endtask

  task automatic test_same_address();
    apply_reset();
    wr_addr = 32'd9; wr_len = 8'd0; wr_req = 1'b1;
    rd_addr = 32'd9; rd_len = 8'd0; rd_req = 1'b1;
    for (int k = 0; k < 4; k++) run_burst(1'b1, 0, 4'b0001, 1'b0, "same_addr_wr");
    run_burst(1'b1, 0, 4'b0001, 1'b1, "same_addr_raw_wr");
    run_burst(1'b0, 0, 4'b0001, 1'b1, "same_addr_rd");
  endtask

  task automatic test_max_len();
    apply_reset();
    wr_addr = 32'h0000_00F0; wr_len = 8'd255; wr_req = 1'b1;
    run_burst(1'b1, 255, 4'b1000, 1'b1, "max_len");
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] cnt;
    apply_reset();
    wr_addr = 32'd9; wr_len = 8'd7; wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apb_beat_done = 1'b1;
      tick();
      apb_beat_done = 1'b0;
      cnt = 8'(i + 1);
      checks++;
      if (obs() !== {6'b101110, 4'b0001, cnt}) begin
        failures++;
        $display("FAIL mid_beat %0d: got %b expected %b", i, obs(), {6'b101110, 4'b0001, cnt});
      end
    end
    rd_addr = 32'd58; rd_len = 8'd0; rd_req = 1'b1;
    ARESET = 1'b1; apb_beat_done = 1'b1;
    tick();
    ARESET = 1'b0; apb_beat_done = 1'b0;
    checks++;
    if (obs() !== 18'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got %b expected %b", obs(), 18'd0);
    end
    tick();
    rd_req = 1'b0;
    checks++;
    if (obs() !== {6'b011010, 4'b1000, 8'd0}) begin
      failures++;
      $display("FAIL mid_reset_rd_grant: got %b expected %b", obs(), {6'b011010, 4'b1000, 8'd0});
    end
    apb_beat_done = 1'b1;
    tick();
    apb_beat_done = 1'b0;
    checks++;
    if (obs() !== {6'b000011, 4'b0000, 8'd1}) begin
      failures++;
      $display("FAIL mid_reset_rd_done: got %b expected %b", obs(), {6'b000011, 4'b0000, 8'd1});
    end
    tick();
  endtask

  initial begin
    ARESET = 1'b1; wr_req = 1'b0; rd_req = 1'b0; apb_beat_done = 1'b0;
    wr_addr = '0; wr_len = '0; rd_addr = '0; rd_len = '0;
    test_reset();
    test_idle_beat_ignored();
    test_single_write();
    test_read_burst();
    test_simultaneous();
    test_starvation();
    test_same_address();
    test_max_len();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_apb_rw_arbiter.md
AXI_APB_RW_ARBITER -- requirements
Module: axi_apb_rw_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 32, address width; LEN_WIDTH, default 8, AXI burst length width; STARVE_LIMIT, default 4, maximum consecutive write grants while a read is pending; SEL_LSB, default 4, LSB of the 2-bit slave-select field.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports, in order:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous active-high reset.
- wr_req  in  1  write burst pending (level).
- wr_addr  in  ADDR_WIDTH  write start address.
- wr_len  in  LEN_WIDTH  write beats minus 1.
- rd_req  in  1  read burst pending (level).
- rd_addr  in  ADDR_WIDTH  read start address.
- rd_len  in  LEN_WIDTH  read beats minus 1.
- apb_beat_done  in  1  one APB transfer completed (PREADY in access phase).
- wr_grant  out  1  write burst owns the APB master.
- rd_grant  out  1  read burst owns the APB master.
- apb_start  out  1  one-cycle pulse: start next APB transfer.
- apb_write  out  1  direction of the current transfer.
- beat_cnt  out  LEN_WIDTH  beats completed in the current burst.
- burst_done  out  1  one-cycle pulse after the last beat.
- slv_sel  out  4  one-hot PSEL1..PSEL4 decode.
- busy  out  1  state is not IDLE.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, WR, RD, DONE.
REQ-005 Requests SHALL be sampled only in IDLE; requests arriving in WR, RD or DONE SHALL be held off and not lost.
REQ-006 In IDLE, the arbiter SHALL select as follows:
- only wr_req set: go to WR.
- only rd_req set: go to RD.
- both set: go to WR, except go to RD when wr_streak equals STARVE_LIMIT.
- both set and rd_addr equals wr_addr: go to WR regardless of wr_streak (read-after-write ordering).
REQ-007 On the grant edge, the block SHALL latch the granted address and len. wr_grant or rd_grant and the first apb_start SHALL be asserted in the cycle after the request was seen in IDLE.
REQ-008 apb_write SHALL equal wr_grant. slv_sel SHALL be 1 << latched_addr[SEL_LSB+1:SEL_LSB] while granted, else 0.
REQ-009 beat_cnt SHALL clear to 0 on grant and increment on each apb_beat_done while granted. apb_beat_done outside WR or RD SHALL be ignored.
REQ-010 On apb_beat_done with beat_cnt not equal to latched len, apb_start SHALL pulse in the next cycle.
REQ-011 On apb_beat_done with beat_cnt equal to latched len:
- next cycle: state DONE, grants low, burst_done high.
- the cycle after: IDLE.
REQ-012 len equal to 2^LEN_WIDTH-1 SHALL give 2^LEN_WIDTH beats; beat_cnt SHALL wrap to 0 only on the final beat.
REQ-013 The wr_streak counter, width clog2(STARVE_LIMIT+1), SHALL:
- increment on each WR grant, saturating at STARVE_LIMIT.
- clear on each RD grant.
REQ-014 wr_grant and rd_grant SHALL never be high in the same cycle.
REQ-015 apb_start SHALL never be asserted outside WR or RD.

Reset
REQ-016 With ARESET sampled high, at the same edge the block SHALL set:
- state IDLE.
- all outputs 0.
- beat_cnt 0 and wr_streak 0.
- latched address and len 0.
REQ-017 A reset mid-burst SHALL abandon the burst without a burst_done pulse. Arbitration SHALL resume in the first cycle after ARESET falls.

Structure
REQ-018 A shared package axi_apb_pkg SHALL hold:
- the state enum arb_state_t (IDLE, WR, RD, DONE).
- the default widths.
- the slave-select field constants.
REQ-019 The slave decode SHALL be one sub-module, apb_slave_decoder (address in, one-hot 4-bit out), reused by the bridge.

Verification
REQ-020 Single write: wr_req=1, wr_addr=9, wr_len=0, apb_beat_done one cycle after apb_start -> wr_grant=1 and slv_sel=0001 for one beat, then burst_done pulse, busy=0 two cycles after apb_beat_done.
REQ-021 Read burst: rd_req=1, rd_addr=58, rd_len=7, 8 apb_beat_done pulses -> 8 apb_start pulses, apb_write=0, slv_sel=1000, beat_cnt 0..7, then burst_done.
REQ-022 Simultaneous requests, wr_addr=9, rd_addr=38 -> WR first (slv_sel=0001), then RD (slv_sel=0100) after DONE.
REQ-023 Starvation: wr_req held high with back-to-back len=0 bursts, rd_req=1, rd_addr=47, STARVE_LIMIT=4 -> exactly 4 write grants, then rd_grant.
REQ-024 Same address: wr_addr=rd_addr=9 with wr_streak=4 -> WR granted before RD.
REQ-025 Reset mid-burst: ARESET=1 at beat 3 of an 8-beat write -> all outputs 0 next edge, no burst_done; a pending rd_req is granted after release.
